timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 103 ++++++++++
 tb/tb_timer_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a level interrupt.
// Optional auto-reload path is built only when TIMER_RELOAD_EN is defined.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [3:0]  ctrl_reg;
    logic [31:0] preset_reg;
    logic [31:0] count_reg;
    logic        irq_pend_reg;

    logic wr_ctrl;
    logic wr_preset;
    logic reload_mode;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);

`ifdef TIMER_RELOAD_EN
    assign reload_mode = (ctrl_reg[2:1] == 2'b01);
`else
    assign reload_mode = 1'b0;
`endif

    // Later assignments in this block override earlier ones, which gives the
    // required priorities: flag set beats a bus clear, bus CTRL write beats EN clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            ctrl_reg     <= 4'd0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            irq_pend_reg <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl_reg <= wdata[3:0];
            if (wr_preset)
                preset_reg <= wdata;
            if (wr_ctrl || wr_preset)
                irq_pend_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (ctrl_reg[0])
                        state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_reg[0]) begin
                        state_reg <= S_IDLE;
                    end else if (count_reg > 32'd1) begin
                        count_reg <= count_reg - 32'd1;
                    end else begin
                        count_reg    <= 32'd0;
                        irq_pend_reg <= 1'b1;
                        state_reg    <= S_INT;
                    end
                end
                S_INT: begin
                    if (reload_mode) begin
                        irq_pend_reg <= 1'b0;
                        state_reg    <= S_LOAD;
                    end else begin
                        if (!wr_ctrl)
                            ctrl_reg[0] <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, ctrl_reg};
            2'd1:    rdata = preset_reg;
            2'd2:    rdata = count_reg;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = irq_pend_reg & ctrl_reg[3];

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed scenarios plus random bus traffic,
// checked against a schedule-based reference model (expiry edge computed from PRESET).
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: the timer is described by the edge it was armed (m_t)
    // and the edge it expires (m_exp); COUNT is derived from elapsed edges.
    logic [3:0]  m_ctrl   = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count  = 32'd0;
    logic        m_pend   = 1'b0;
    bit          m_run    = 1'b0;
    longint      m_edge   = 0;
    longint      m_t      = 0;
    longint      m_exp    = 0;
    longint      m_p      = 0;

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        logic [3:0] old_ctrl;
        logic [31:0] old_preset;
        bit wr_ctrl, wr_pre, set_pend, clr_en, reload_clr, rl;
        m_edge++;
        if (r) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_run = 1'b0;
            return;
        end
        old_ctrl   = m_ctrl;
        old_preset = m_preset;
        wr_ctrl    = w && (a == 2'd0);
        wr_pre     = w && (a == 2'd1);
        set_pend   = 0; clr_en = 0; reload_clr = 0;
`ifdef TIMER_RELOAD_EN
        rl = (old_ctrl[2:1] == 2'b01);
`else
        rl = 0;
`endif
        if (!m_run) begin
            if (old_ctrl[0]) begin
                m_run = 1; m_t = m_edge;
            end
        end else if (m_edge == m_t + 1) begin
            m_p     = longint'(old_preset);
            m_count = old_preset;
            m_exp   = m_t + 1 + ((m_p == 0) ? 1 : m_p);
        end else if (m_edge <= m_exp) begin
            if (!old_ctrl[0])
                m_run = 0;
            else if (m_edge == m_exp) begin
                m_count = 32'd0; set_pend = 1;
            end else
                m_count = 32'(m_p - (m_edge - m_t - 1));
        end else begin
            if (rl) begin
                reload_clr = 1; m_t = m_edge;
            end else begin
                clr_en = 1; m_run = 0;
            end
        end
        if (set_pend) m_pend = 1'b1;
        else if (wr_ctrl || wr_pre || reload_clr) m_pend = 1'b0;
        if (wr_ctrl) m_ctrl = d[3:0];
        else if (clr_en) m_ctrl[0] = 1'b0;
        if (wr_pre) m_preset = d;
    endtask

    // One bus cycle: present inputs, queue the expected response, advance the model at the edge.
    task automatic drive(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        exp_t x;
        reset = r; we = w; addr = a; wdata = d;
        x.a = a; x.rd = model_rdata(a); x.irq = m_pend & m_ctrl[3];
        sb.push_back(x);
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            n_total++;
            if (rdata === x.rd) n_pass++;
            else $display("FAIL rdata addr=%0d t=%0t got=%h exp=%h", x.a, $time, rdata, x.rd);
            n_total++;
            if (irq === x.irq) n_pass++;
            else $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, x.irq);
        end
    end

    initial begin
        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        @(posedge clk); #1;

        // Reset and read-back of every address
        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 2'(i), 0);

        // One-shot, PRESET=5, IM set; clear with CTRL write
        drive(0, 1, 1, 32'd5);
        drive(0, 1, 0, 32'h9);
        repeat (12) drive(0, 0, 2, 0);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 32'h8);
        repeat (2) drive(0, 0, 0, 0);

        // Auto-reload, PRESET=3 (single held irq when reload is not built)
        drive(0, 1, 1, 32'd3);
        drive(0, 1, 0, 32'hB);
        repeat (25) drive(0, 0, 2, 0);
        drive(0, 1, 0, 32'h0);

        // Disable mid-count freezes COUNT at 6, re-enable reloads 10
        drive(0, 1, 1, 32'd10);
        drive(0, 1, 0, 32'h9);
        repeat (5) drive(0, 0, 2, 0);
        drive(0, 1, 0, 32'h0);
        repeat (4) drive(0, 0, 2, 0);
        drive(0, 1, 0, 32'h9);
        repeat (4) drive(0, 0, 2, 0);
        drive(0, 1, 0, 32'h0);

        // PRESET=0 then PRESET=1
        for (int p = 0; p < 2; p++) begin
            drive(0, 1, 1, 32'(p));
            drive(0, 1, 0, 32'h9);
            repeat (6) drive(0, 0, 0, 0);
            drive(0, 1, 0, 32'h0);
        end

        // Masked one-shot, then clear with CTRL=8
        drive(0, 1, 1, 32'd2);
        drive(0, 1, 0, 32'h1);
        repeat (8) drive(0, 0, 2, 0);
        drive(0, 1, 0, 32'h8);
        repeat (3) drive(0, 0, 0, 0);

        // Reset while counting
        drive(0, 1, 1, 32'd20);
        drive(0, 1, 0, 32'h9);
        repeat (5) drive(0, 0, 2, 0);
        drive(1, 0, 2, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 2'(i), 0);

        // Maximum PRESET counts down without wrapping
        drive(0, 1, 1, 32'hFFFF_FFFF);
        drive(0, 1, 0, 32'h9);
        repeat (10) drive(0, 0, 2, 0);
        drive(0, 1, 0, 32'h0);

        // Random bus traffic
        for (int n = 0; n < 3000; n++) begin
            bit          r, w;
            logic [1:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 7) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1) begin
                case ($urandom_range(0, 9))
                    8:       d = 32'hFFFF_FFFF;
                    9:       d = $urandom;
                    default: d = 32'($urandom_range(0, 9));
                endcase
            end
            drive(r, w, a, d);
        end

        repeat (3) @(negedge clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
